bus_mux_reg: RTL and testbench
==============================

BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 Parameter WIDTH, 16, bit width of every source word and of the output bus.
REQ-002 Parameter N_SRC, 16, number of source slots, in the range 2..16.
REQ-003 Parameter SEL_W, 4, select width; SHALL satisfy 2**SEL_W >= N_SRC.
REQ-004 Parameter ILLEGAL_ZERO, 0: 1 drives zero data on an illegal select; 0 repeats the last legal data.
REQ-005 Port clk  in  1  single system clock; all state SHALL change on the rising edge.
REQ-006 Port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 Port src_flat  in  N_SRC*WIDTH  concatenated sources; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port src_en  in  N_SRC  populated-slot mask; bit k = 1 marks slot k as legal.
REQ-009 Port sel  in  SEL_W  requested slot index.
REQ-010 Port sel_valid  in  1  a select request is present.
REQ-011 Port sel_ready  out  1  the block accepts the request this cycle.
REQ-012 Port data_out  out  WIDTH  registered bus word.
REQ-013 Port out_valid  out  1  data_out holds an unconsumed word.
REQ-014 Port out_ready  in  1  the consumer takes the word this cycle.
REQ-015 Port sel_err  out  1  the word held in data_out came from an illegal select.
REQ-016 Port err_cnt  out  8  saturating count of illegal selects accepted.

Function
REQ-017 A request SHALL be accepted only in a cycle where sel_valid and sel_ready are both 1.
REQ-018 A select SHALL be legal only when sel < N_SRC and src_en[sel] = 1.
REQ-019 The block SHALL use a two-state FSM:
- EMPTY: no word is held.
- FULL: a word is held, and out_valid = 1.
REQ-020 sel_ready SHALL equal (state == EMPTY) or out_ready, so that back-to-back transfers sustain one word per cycle.
REQ-021 Acceptance latency:
- On acceptance of a legal select, data_out SHALL equal that slot's src_flat word, sampled in the accept cycle, on the next cycle.
- In that same next cycle, out_valid = 1 and sel_err = 0.
REQ-022 On acceptance of an illegal select:
- data_out = 0 when ILLEGAL_ZERO = 1; otherwise data_out = the last legal word, or 0 if none has been accepted since reset.
- sel_err = 1 and out_valid = 1 on the next cycle.
REQ-023 Every illegal acceptance SHALL increment err_cnt by 1, and err_cnt SHALL hold at 255.
REQ-024 FSM transitions:
- EMPTY to FULL on acceptance.
- FULL to EMPTY on out_ready with no acceptance.
- FULL stays FULL when out_ready and acceptance occur in the same cycle, and the register is replaced by the new word.
REQ-025 In FULL with out_ready = 0, data_out, sel_err and out_valid SHALL stay stable, and src_flat changes SHALL NOT affect data_out.
REQ-026 Changes on src_en or src_flat SHALL affect only requests accepted after the change.
REQ-027 out_valid, data_out and sel_err SHALL be driven from registers only, with no combinational path from the inputs.

Reset
REQ-028 rst_n low SHALL immediately force:
- state = EMPTY;
- data_out = 0, out_valid = 0, sel_err = 0, err_cnt = 0;
- the last-legal-word register = 0.
REQ-029 A reset asserted mid-transfer SHALL discard the held word, and no out_valid pulse SHALL follow deassertion.
REQ-030 The first acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold:
- the state enum (EMPTY, FULL);
- the processor slot-index constants: RA=0, RB=1, RC=2, R1=3, R2=4, R3=5, DR=6, AC=9, PC=10;
- the default src_en mask 16'h067F.
REQ-032 Slot decode (index plus mask to data and legal) SHALL be a single combinational sub-module, bus_slot_decode; the FSM and registers SHALL reside in bus_mux_reg.

Verification
REQ-033 Reset, then sel=10 with src slot 10 = 16'hBEEF, sel_valid held one cycle, out_ready=1 -> the next cycle gives data_out=16'hBEEF, out_valid=1, sel_err=0.
REQ-034 Default mask, sel=7 after a legal 16'h1234 word, ILLEGAL_ZERO=0 -> data_out=16'h1234, sel_err=1, err_cnt=1; with ILLEGAL_ZERO=1 -> data_out=0.
REQ-035 out_ready=0 for 5 cycles after a legal accept, with src_flat changing every cycle -> data_out is constant, sel_ready=0 and out_valid=1 throughout.
REQ-036 Continuous sel_valid with sel cycling 0..6 and out_ready=1 -> 7 words on 7 consecutive cycles, in order, with no bubbles.
REQ-037 300 back-to-back illegal selects -> err_cnt=255, with no wrap to 0.
REQ-038 rst_n pulsed low mid-stream while FULL -> out_valid falls immediately, err_cnt=0, and the first post-reset accept appears one cycle after acceptance.

Source files
------------

// File: rtl/bus_mux_reg_pkg.sv
// Shared definitions for the registered bus multiplexer.
//   state_e        : two-state output-register FSM (EMPTY / FULL)
//   slot constants : processor register slot indices on the bus
//   DEFAULT_SRC_EN : populated-slot mask of the reference processor
//   sat_inc8       : saturating 8-bit increment used by the error counter
package bus_mux_reg_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int RA = 0;
  localparam int RB = 1;
  localparam int RC = 2;
  localparam int R1 = 3;
  localparam int R2 = 4;
  localparam int R3 = 5;
  localparam int DR = 6;
  localparam int AC = 9;
  localparam int PC = 10;

  localparam logic [15:0] DEFAULT_SRC_EN = 16'h067F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_mux_reg_if.sv
// Select/output handshake bundle of bus_mux_reg.
//   slave  : the multiplexer side (takes sources and select, drives the bus word)
//   master : the requester/consumer side
//   src_flat  - N_SRC concatenated source words, slot k at [k*WIDTH +: WIDTH]
//   src_en    - populated-slot mask
//   sel / sel_valid / sel_ready   - select request handshake
//   data_out / out_valid / out_ready - registered output handshake
//   sel_err   - held word came from an illegal select
//   err_cnt   - saturating count of accepted illegal selects
interface bus_mux_reg_if #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 16,
  parameter int SEL_W = 4
) ();

  logic [N_SRC*WIDTH-1:0] src_flat;
  logic [N_SRC-1:0]       src_en;
  logic [SEL_W-1:0]       sel;
  logic                   sel_valid;
  logic                   sel_ready;
  logic [WIDTH-1:0]       data_out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sel_err;
  logic [7:0]             err_cnt;

  modport slave (
    input  src_flat, src_en, sel, sel_valid, out_ready,
    output sel_ready, data_out, out_valid, sel_err, err_cnt
  );

  modport master (
    output src_flat, src_en, sel, sel_valid, out_ready,
    input  sel_ready, data_out, out_valid, sel_err, err_cnt
  );

endinterface

// File: rtl/bus_mux_reg_slot_decode.sv
// bus_slot_decode: purely combinational slot decoder.
//   src_flat_i - concatenated source words
//   src_en_i   - populated-slot mask
//   sel_i      - requested slot index
//   data_o     - word of the selected slot (0 when the index is out of range)
//   legal_o    - index is in range and its slot is populated
module bus_slot_decode #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 16,
  parameter int SEL_W = 4
) (
  input  logic [N_SRC*WIDTH-1:0] src_flat_i,
  input  logic [N_SRC-1:0]       src_en_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   legal_o
);

  // Compare against every in-range slot instead of indexing directly, so an
  // index >= N_SRC simply matches nothing and decodes as illegal.
  always_comb begin
    data_o  = '0;
    legal_o = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o  = src_flat_i[k*WIDTH +: WIDTH];
        legal_o = src_en_i[k];
      end
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: selects one of N_SRC source words and holds it in an output
// register with a valid/ready handshake; illegal selects are flagged and
// counted.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bus_mux_reg_if slave modport (select request, output word, status)
// ILLEGAL_ZERO = 1 outputs zero on an illegal select, 0 repeats the last legal
// word (zero if none since reset). SEL_W must satisfy 2**SEL_W >= N_SRC.
module bus_mux_reg
  import bus_mux_reg_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int N_SRC        = 16,
  parameter int SEL_W        = 4,
  parameter bit ILLEGAL_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_mux_reg_if.slave      bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] last_q,  last_d;
  logic             err_q,   err_d;
  logic [7:0]       cnt_q,   cnt_d;

  logic [WIDTH-1:0] slot_data;
  logic             slot_legal;
  logic             accept;

  bus_slot_decode #(
    .WIDTH (WIDTH),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_decode (
    .src_flat_i (bus.src_flat),
    .src_en_i   (bus.src_en),
    .sel_i      (bus.sel),
    .data_o     (slot_data),
    .legal_o    (slot_legal)
  );

  assign accept = bus.sel_valid && bus.sel_ready;

  // State and output-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: an acceptance always leaves the register FULL (a drain and a
  // refill in the same cycle just replaces the word).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Register contents load only on acceptance, so a stalled word is immune
  // to later source or mask changes.
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (accept) begin
      if (slot_legal) begin
        data_d = slot_data;
        last_d = slot_data;
        err_d  = 1'b0;
      end else begin
        data_d = ILLEGAL_ZERO ? '0 : last_q;
        err_d  = 1'b1;
        cnt_d  = sat_inc8(cnt_q);
      end
    end
  end

  // Outputs: bus word, flag and valid come straight from registers.
  always_comb begin
    bus.out_valid = (state_q == FULL);
    bus.sel_ready = (state_q == EMPTY) || bus.out_ready;
    bus.data_out  = data_q;
    bus.sel_err   = err_q;
    bus.err_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: two instances (ILLEGAL_ZERO = 0 and 1)
// share the same stimulus.
module tb_bus_mux_reg;
  import bus_mux_reg_pkg::*;

  localparam int WIDTH = 16;
  localparam int N_SRC = 16;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_SRC*WIDTH-1:0] src_flat;
  logic [N_SRC-1:0]       src_en;
  logic [SEL_W-1:0]       sel;
  logic                   sel_valid;
  logic                   out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_mux_reg_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus0 ();
  bus_mux_reg_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus1 ();

  assign bus0.src_flat  = src_flat;
  assign bus0.src_en    = src_en;
  assign bus0.sel       = sel;
  assign bus0.sel_valid = sel_valid;
  assign bus0.out_ready = out_ready;
  assign bus1.src_flat  = src_flat;
  assign bus1.src_en    = src_en;
  assign bus1.sel       = sel;
  assign bus1.sel_valid = sel_valid;
  assign bus1.out_ready = out_ready;

  bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ILLEGAL_ZERO(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ILLEGAL_ZERO(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [WIDTH-1:0] v);
    src_flat[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel_valid = 1'b0;
    out_ready = 1'b1;
    sel = '0;
    src_flat = '0;
    src_en = DEFAULT_SRC_EN;
    repeat (2) tick();
    total++; if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b/%b exp=0", bus0.out_valid, bus1.out_valid); end
    total++; if (bus0.data_out !== 16'h0 || bus1.data_out !== 16'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0000", bus0.data_out, bus1.data_out); end
    total++; if (bus0.sel_err !== 1'b0 || bus0.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%b cnt=%0d exp=0 cnt=0", bus0.sel_err, bus0.err_cnt); end
    total++; if (bus0.sel_ready !== 1'b1) begin bad++; $display("FAIL reset_sel_ready got=%b exp=1", bus0.sel_ready); end
    rst_n = 1'b1;
  endtask

  // Also the first acceptance right after reset deassertion.
  task automatic test_legal();
    set_slot(PC, 16'hBEEF);
    sel = SEL_W'(PC);
    sel_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    total++; if (bus0.data_out !== 16'hBEEF || bus1.data_out !== 16'hBEEF) begin bad++; $display("FAIL legal_data got=%h/%h exp=beef", bus0.data_out, bus1.data_out); end
    total++; if (bus0.out_valid !== 1'b1 || bus0.sel_err !== 1'b0) begin bad++; $display("FAIL legal_flags got=ov%b err%b exp=ov1 err0", bus0.out_valid, bus0.sel_err); end
    tick();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL legal_drain got=%b exp=0", bus0.out_valid); end
  endtask

  task automatic test_illegal();
    set_slot(RA, 16'h1234);
    sel = SEL_W'(RA);
    sel_valid = 1'b1;
    tick();
    sel = 4'd7;
    tick();
    total++; if (bus0.data_out !== 16'h1234) begin bad++; $display("FAIL illegal_repeat got=%h exp=1234", bus0.data_out); end
    total++; if (bus1.data_out !== 16'h0000) begin bad++; $display("FAIL illegal_zero got=%h exp=0000", bus1.data_out); end
    total++; if (bus0.sel_err !== 1'b1 || bus1.sel_err !== 1'b1 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL illegal_flags got=err%b/%b ov%b exp=err1/1 ov1", bus0.sel_err, bus1.sel_err, bus0.out_valid); end
    total++; if (bus0.err_cnt !== 8'd1 || bus1.err_cnt !== 8'd1) begin bad++; $display("FAIL illegal_cnt got=%0d/%0d exp=1", bus0.err_cnt, bus1.err_cnt); end
    sel = 4'd12;
    tick();
    total++; if (bus0.err_cnt !== 8'd2 || bus0.data_out !== 16'h1234) begin bad++; $display("FAIL illegal_unpop got=cnt%0d data%h exp=cnt2 data1234", bus0.err_cnt, bus0.data_out); end
    src_en = DEFAULT_SRC_EN | 16'h0080;
    set_slot(7, 16'h5A5A);
    sel = 4'd7;
    tick();
    total++; if (bus1.data_out !== 16'h5A5A || bus1.sel_err !== 1'b0 || bus1.err_cnt !== 8'd2) begin bad++; $display("FAIL mask_change got=%h err%b cnt%0d exp=5a5a err0 cnt2", bus1.data_out, bus1.sel_err, bus1.err_cnt); end
    src_en = DEFAULT_SRC_EN;
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    set_slot(R1, 16'h1111);
    sel = SEL_W'(R1);
    sel_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_slot(R1, 16'h2000 + 16'(i));
      #1;
      total++; if (bus0.sel_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d got=%b exp=0", i, bus0.sel_ready); end
      tick();
      total++; if (bus0.data_out !== 16'h1111 || bus0.out_valid !== 1'b1 || bus0.sel_err !== 1'b0) begin bad++; $display("FAIL stall_hold c%0d got=%h ov%b err%b exp=1111 ov1 err0", i, bus0.data_out, bus0.out_valid, bus0.sel_err); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (bus0.sel_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", bus0.sel_ready); end
    tick();
    total++; if (bus0.data_out !== 16'h2004 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL stall_replace got=%h ov%b exp=2004 ov1", bus0.data_out, bus0.out_valid); end
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) set_slot(k, 16'h1000 + 16'(k));
    out_ready = 1'b1;
    sel = 4'd0;
    sel_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      total++; if (bus0.data_out !== 16'h1000 + 16'(k) || bus0.out_valid !== 1'b1 || bus0.sel_err !== 1'b0) begin bad++; $display("FAIL b2b w%0d got=%h ov%b err%b exp=%h ov1 err0", k, bus0.data_out, bus0.out_valid, bus0.sel_err, 16'h1000 + 16'(k)); end
      if (k < 6) sel = SEL_W'(k + 1);
      else sel_valid = 1'b0;
    end
    tick();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus0.out_valid); end
  endtask

  task automatic test_err_sat();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    sel = 4'd7;
    sel_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) begin
        total++; if (bus0.err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", bus0.err_cnt); end
      end
      if (i == 255) begin
        total++; if (bus0.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", bus0.err_cnt); end
      end
    end
    total++; if (bus0.err_cnt !== 8'd255 || bus1.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=255", bus0.err_cnt, bus1.err_cnt); end
    total++; if (bus0.data_out !== 16'h0000 || bus0.sel_err !== 1'b1) begin bad++; $display("FAIL sat_no_legal got=%h err%b exp=0000 err1", bus0.data_out, bus0.sel_err); end
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_slot(AC, 16'hCAFE);
    sel = SEL_W'(AC);
    sel_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (bus0.data_out !== 16'hCAFE || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h ov%b exp=cafe ov1", bus0.data_out, bus0.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus0.out_valid !== 1'b0 || bus0.err_cnt !== 8'd0 || bus0.data_out !== 16'h0) begin bad++; $display("FAIL mid_async got=ov%b cnt%0d data%h exp=ov0 cnt0 data0000", bus0.out_valid, bus0.err_cnt, bus0.data_out); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_pulse got=%b exp=0", bus0.out_valid); end
    set_slot(DR, 16'h7777);
    sel = SEL_W'(DR);
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    total++; if (bus0.data_out !== 16'h7777 || bus0.out_valid !== 1'b1 || bus0.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_post got=%h ov%b cnt%0d exp=7777 ov1 cnt0", bus0.data_out, bus0.out_valid, bus0.err_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_err_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
